// File: rtl/mdu_seq.sv
// Multi-cycle RISC-V M-extension unit: radix-2 shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN skips iteration for zero multiplicands and zero divisors.
module mdu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       S,
    input  logic             un,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [3:0] OpMul  = 4'b0111;
    localparam logic [3:0] OpMulh = 4'b1000;
    localparam logic [3:0] OpDiv  = 4'b1001;
    localparam logic [3:0] OpRem  = 4'b1010;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              fix_q;
    logic [3:0]        op_q;
    logic              sgn_q;
    logic              dz_q;
    logic [WIDTH-1:0]  xorig_q;
    logic [WIDTH-1:0]  opb_q;
    logic [W2-1:0]     prod_q;
    logic [WIDTH-1:0]  result_q;

    logic              req_mul, req_div, req_ok, early;
    logic              xneg, yneg;
    logic [WIDTH-1:0]  xmag, ymag, early_res;
    logic              is_mul;
    logic [WIDTH-1:0]  prod_hi, prod_lo;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH+1:0]  div_diff;
    logic [W2-1:0]     step_next, neg_next;
    logic [WIDTH-1:0]  sel_res;

    assign req_mul = (S == OpMul) || (S == OpMulh);
    assign req_div = (S == OpDiv) || (S == OpRem);
    assign req_ok  = req_mul || req_div;
    assign xneg    = ~un & X[WIDTH-1];
    assign yneg    = ~un & Y[WIDTH-1];
    assign xmag    = xneg ? -X : X;
    assign ymag    = yneg ? -Y : Y;

`ifdef MDU_EARLY_OUT_EN
    assign early = (req_mul && ((X == '0) || (Y == '0))) || (req_div && (Y == '0));
`else
    assign early = 1'b0;
`endif

    assign early_res = (S == OpDiv) ? '1 : ((S == OpRem) ? X : '0);

    assign is_mul  = (op_q == OpMul) || (op_q == OpMulh);
    assign prod_hi = prod_q[W2-1:WIDTH];
    assign prod_lo = prod_q[WIDTH-1:0];

    // Multiply: product high half accumulates, multiplier shifts out of the low half.
    // Divide: remainder lives in the high half, dividend/quotient bits in the low half.
    assign mul_sum  = {1'b0, prod_hi} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign div_diff = {1'b0, prod_hi, prod_lo[WIDTH-1]} - {2'b0, opb_q};

    always_comb begin
        step_next = '0;
        if (is_mul) begin
            step_next = {mul_sum, prod_lo[WIDTH-1:1]};
        end else if (div_diff[WIDTH+1]) begin
            step_next = {prod_q[W2-2:0], 1'b0};
        end else begin
            step_next = {div_diff[WIDTH-1:0], prod_lo[WIDTH-2:0], 1'b1};
        end
    end

    // mulh needs the full-width negation; quotient and remainder negate independently.
    assign neg_next = is_mul ? -prod_q : {-prod_hi, -prod_lo};

    always_comb begin
        sel_res = '0;
        case (op_q)
            OpMul:   sel_res = prod_lo;
            OpMulh:  sel_res = prod_hi;
            OpDiv:   sel_res = dz_q ? '1 : prod_lo;
            OpRem:   sel_res = dz_q ? xorig_q : prod_hi;
            default: sel_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (!req_ok || early) ? StDone : StRun;
                end
            end
            StRun: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (fix_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            fix_q    <= 1'b0;
            op_q     <= '0;
            sgn_q    <= 1'b0;
            dz_q     <= 1'b0;
            xorig_q  <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q    <= S;
                        sgn_q   <= (S == OpRem) ? xneg : (xneg ^ yneg);
                        dz_q    <= (Y == '0);
                        xorig_q <= X;
                        cnt_q   <= '0;
                        fix_q   <= 1'b0;
                        opb_q   <= req_mul ? xmag : ymag;
                        prod_q  <= {{WIDTH{1'b0}}, (req_mul ? ymag : xmag)};
                        if (!req_ok || early) begin
                            result_q <= req_ok ? early_res : '0;
                        end
                    end
                end
                StRun: begin
                    prod_q <= step_next;
                    cnt_q  <= cnt_q + CW'(1);
                end
                StFix: begin
                    // Two FIX cycles: sign correction first, then result selection.
                    if (!fix_q) begin
                        if (sgn_q) begin
                            prod_q <= neg_next;
                        end
                        fix_q <= 1'b1;
                    end else begin
                        result_q <= sel_res;
                    end
                end
                StDone: begin
                end
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StDone);
    assign result    = result_q;

endmodule
